mul8s_share_sched: RTL and testbench

- Round-robin scheduler that shares one combinational 8x8 signed approximate multiplier (mul8s family) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready channels and drives registered operands to the external multiplier.
- Samples the 16-bit product one cycle later and returns it on a single shared response channel tagged with the requester ID.
- Sits between the accelerator's request fabric and the multiplier instance.

---
 rtl/mul8s_share_sched.sv | 131 +++++++++++++
 tb/tb_mul8s_share_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8s_share_sched.sv
// Round-robin sharing of one external 8x8 signed multiplier among NREQ requesters.
// Optional error monitor (rsp_err / err_max) enabled by defining MUL8S_SHARE_ERR_MON_EN.
module mul8s_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [16:0]       rsp_err,
  output logic [15:0]       err_max,
  output logic              busy
);

  logic [7:0]     a_arr [NREQ];
  logic [7:0]     b_arr [NREQ];
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] s1_id_reg;
  logic           s1_v_reg;
  logic           s2_v_reg;
  logic           adv1;
  logic           adv2;
  logic           any;
  logic           accept;
  logic [IDW-1:0] win;
  int             k;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[8*gi +: 8];
    assign b_arr[gi] = req_b[8*gi +: 8];
  end

  assign adv2   = !s2_v_reg || rsp_ready;
  assign adv1   = !s1_v_reg || adv2;
  assign accept = any && adv1;

  // First valid requester at or after ptr_reg, wrapping around.
  always_comb begin
    any = 1'b0;
    win = '0;
    k   = 0;
    for (int j = 0; j < NREQ; j++) begin
      k = int'(ptr_reg) + j;
      if (k >= NREQ) k = k - NREQ;
      if (!any && req_valid[IDW'(k)]) begin
        any = 1'b1;
        win = IDW'(k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (any && adv1 && !reset) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_reg   <= '0;
      s1_v_reg  <= 1'b0;
      s1_id_reg <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      s2_v_reg  <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      // Operands hold when S1 empties so the multiplier inputs stay quiet.
      if (adv1) begin
        s1_v_reg <= accept;
        if (accept) begin
          mul_a     <= a_arr[win];
          mul_b     <= b_arr[win];
          s1_id_reg <= win;
          ptr_reg   <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
        end
      end
      if (adv2) begin
        s2_v_reg <= s1_v_reg;
        if (s1_v_reg) begin
          rsp_data <= mul_o;
          rsp_id   <= s1_id_reg;
        end
      end
    end
  end

  assign rsp_valid = s2_v_reg;
  assign busy      = s1_v_reg || s2_v_reg;

`ifdef MUL8S_SHARE_ERR_MON_EN
  logic [16:0] ax_ext;
  logic [16:0] bx_ext;
  logic [16:0] exact_w;
  logic [16:0] err_w;
  logic [16:0] abs_w;
  logic [15:0] abs_sat_w;

  // Modular 17-bit arithmetic yields the correct two's-complement result.
  assign ax_ext    = {{9{mul_a[7]}}, mul_a};
  assign bx_ext    = {{9{mul_b[7]}}, mul_b};
  assign exact_w   = ax_ext * bx_ext;
  assign err_w     = {mul_o[15], mul_o} - exact_w;
  assign abs_w     = err_w[16] ? (~err_w + 17'd1) : err_w;
  assign abs_sat_w = abs_w[16] ? 16'hFFFF : abs_w[15:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_err <= '0;
      err_max <= '0;
    end else if (adv2 && s1_v_reg) begin
      rsp_err <= err_w;
      if (abs_sat_w > err_max) err_max <= abs_sat_w;
    end
  end
`else
  assign rsp_err = '0;
  assign err_max = '0;
`endif

endmodule

// File: tb/tb_mul8s_share_sched.sv
// Randomized self-checking bench for mul8s_share_sched against a transaction-level queue model.
module tb_mul8s_share_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_o;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic [16:0]       rsp_err;
  logic [15:0]       err_max;
  logic              busy;

  logic signed [7:0]  a_in [NREQ];
  logic signed [7:0]  b_in [NREQ];
  logic signed [15:0] inj;

  mul8s_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .err_max(err_max), .busy(busy)
  );

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[8*gi +: 8] = a_in[gi];
    assign req_b[8*gi +: 8] = b_in[gi];
  end

  // Behavioural multiplier: exact product plus an injected error.
  assign mul_o = 16'($signed(mul_a) * $signed(mul_b)) + inj;

  typedef struct {
    int id;
    int prod;
    int err;
    bit in_s2;
  } ent_t;

  ent_t            q[$];
  int              m_ptr;
  int              m_errmax;
  int              n_vec;
  int              n_fail;
  logic [NREQ-1:0] acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] v);
    for (int j = 0; j < NREQ; j++) begin
      int kk;
      kk = (m_ptr + j) % NREQ;
      if (v[kk]) return kk;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    int              w;
    bit              stall;
    bit              rr;
    logic [NREQ-1:0] exp_rdy;
    ent_t            e;
    int              ae;
    int              p;
    #2;
    w       = model_winner(req_valid);
    stall   = (q.size() == 2) && !rsp_ready;
    exp_rdy = '0;
    if (w >= 0 && !stall) exp_rdy = NREQ'(1) << w;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'((q.size() > 0) && q[0].in_s2));
    if (q.size() > 0 && q[0].in_s2) begin
      check("rsp_data", 32'(rsp_data), 32'(q[0].prod));
      check("rsp_id", 32'(rsp_id), 32'(q[0].id));
`ifdef MUL8S_SHARE_ERR_MON_EN
      check("rsp_err", 32'(int'($signed(rsp_err))), 32'(q[0].err));
`endif
    end
    check("busy", 32'(busy), 32'(q.size() > 0));
`ifdef MUL8S_SHARE_ERR_MON_EN
    check("err_max", 32'(err_max), 32'(m_errmax));
`else
    check("rsp_err_off", 32'(rsp_err), 32'(0));
    check("err_max_off", 32'(err_max), 32'(0));
`endif
    acc = exp_rdy & req_valid;
    rr  = rsp_ready;
    p   = 0;
    if (w >= 0) p = (int'(a_in[w]) * int'(b_in[w]) + int'(inj)) & 32'hFFFF;
    @(posedge clock);
    if (q.size() > 0 && q[0].in_s2 && rr) void'(q.pop_front());
    if (q.size() > 0 && !q[0].in_s2) begin
      e = q[0];
      e.in_s2 = 1'b1;
      q[0] = e;
      ae = (e.err < 0) ? -e.err : e.err;
      if (ae > 65535) ae = 65535;
      if (ae > m_errmax) m_errmax = ae;
    end
    if (w >= 0 && !stall) begin
      e.id = w; e.prod = p; e.err = int'(inj); e.in_s2 = 1'b0;
      q.push_back(e);
      m_ptr = (w + 1) % NREQ;
    end
    #1;
  endtask

  // Unaccepted valid requests are held; others get fresh random operands.
  task automatic refresh(input logic [NREQ-1:0] mask, input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!(req_valid[i] && !acc[i])) begin
        req_valid[i] = mask[i] && ($urandom_range(0, 99) < pct);
        a_in[i] = 8'($urandom);
        b_in[i] = 8'($urandom);
      end
    end
  endtask

  task automatic reset_async();
    #2;
    reset = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_mul_a", 32'(mul_a), 32'(0));
    check("rst_mul_b", 32'(mul_b), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_err_max", 32'(err_max), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    q.delete();
    m_ptr = 0;
    m_errmax = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_valid = '0;
    acc = '0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      refresh('0, 0);
      if (req_valid == '0 && q.size() == 0) done = 1'b1;
      else cycle();
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
    end
  endtask

  initial begin
    n_vec = 0; n_fail = 0; m_ptr = 0; m_errmax = 0; acc = '0;
    inj = '0; rsp_ready = 1'b1; req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin a_in[i] = 8'sd0; b_in[i] = 8'sd0; end
    #1;
    reset_async();

    // Single request from port 0: 5 * -3.
    req_valid = 4'b0001; a_in[0] = 8'sd5; b_in[0] = -8'sd3;
    #1;
    check("single_ready", 32'(req_ready), 32'(4'b0001));
    cycle();
    req_valid = '0;
    cycle();
    #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'(1));
    check("single_rsp_data", 32'(rsp_data), 32'(16'hFFF1));
    check("single_rsp_id", 32'(rsp_id), 32'(0));
    cycle();
    drain();

    // All requesters continuously from reset, then backpressure.
    reset_async();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin a_in[i] = 8'($urandom); b_in[i] = 8'($urandom); end
    for (int c = 0; c < 8; c++) begin cycle(); refresh('1, 100); end
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin cycle(); refresh('1, 100); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin cycle(); refresh('1, 100); end
    drain();

    // Wrap-around: make ptr=2 via port 1, then ports 1 and 3 compete.
    reset_async();
    req_valid = 4'b0010; a_in[1] = 8'sd7; b_in[1] = 8'sd9;
    cycle();
    refresh('0, 0);
    drain();
    req_valid = 4'b1010;
    a_in[1] = -8'sd12; b_in[1] = 8'sd11; a_in[3] = 8'sd100; b_in[3] = -8'sd128;
    #1;
    check("wrap_first_grant", 32'(req_ready), 32'(4'b1000));
    cycle();
    refresh(4'b1010, 0);
    #1;
    check("wrap_second_grant", 32'(req_ready), 32'(4'b0010));
    cycle();
    drain();

`ifdef MUL8S_SHARE_ERR_MON_EN
    inj = -16'sd255;
    req_valid = 4'b0001; a_in[0] = 8'sd127; b_in[0] = 8'sd127;
    cycle();
    req_valid = '0;
    cycle();
    #1;
    check("errmon_rsp_err", 32'(int'($signed(rsp_err))), 32'(-255));
    check("errmon_err_max", 32'(err_max), 32'(255));
    cycle();
    inj = -16'sd10;
    req_valid = 4'b0001; a_in[0] = 8'sd3; b_in[0] = 8'sd4;
    cycle();
    req_valid = '0;
    cycle();
    #1;
    check("errmon_small_err", 32'(int'($signed(rsp_err))), 32'(-10));
    check("errmon_sticky", 32'(err_max), 32'(255));
    cycle();
    inj = '0;
    drain();
`endif

    // Fill both stages, then reset mid-flight; nothing may emerge afterwards.
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin cycle(); refresh('1, 100); end
    reset_async();
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    req_valid = '1;
    #1;
    check("post_reset_ptr0", 32'(req_ready), 32'(4'b0001));
    cycle();
    refresh('1, 100);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 99) < 70);
      cycle();
      refresh('1, 50);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
